// File: rtl/seq_divider_n.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Ports: clk, rst_n, start/dividend/divisor in; busy, done, quotient, remainder, div_by_zero out.
module seq_divider_n #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   r_q, r_d;
  logic [N-1:0]   q_q, q_d;
  logic [N-1:0]   dvsr_q, dvsr_d;
  logic           zero_q, zero_d;
  logic [N-1:0]   quot_q, quot_d;
  logic [N-1:0]   rem_q, rem_d;
  logic           dbz_q, dbz_d;

  logic [N:0]     t;
  logic [N:0]     diff;
  logic [N-1:0]   r_step;
  logic [N-1:0]   q_step;

  // R stays below the divisor, so the restored value always fits in N bits.
  always_comb begin
    t      = {r_q, q_q[N-1]};
    diff   = t + ~{1'b0, dvsr_q} + {{N{1'b0}}, 1'b1};
    r_step = diff[N] ? t[N-1:0] : diff[N-1:0];
    q_step = {q_q[N-2:0], ~diff[N]};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    dvsr_d  = dvsr_q;
    zero_d  = zero_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          dvsr_d  = divisor;
          q_d     = dividend;
          r_d     = '0;
          cnt_d   = CW'(N);
          zero_d  = (divisor == '0);
          state_d = RUN;
        end
      end
      RUN: begin
        // A zero divisor spends one RUN cycle, then reports.
        if (zero_q) begin
          quot_d  = '1;
          rem_d   = q_q;
          dbz_d   = 1'b1;
          state_d = DONE;
        end else begin
          r_d   = r_step;
          q_d   = q_step;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            quot_d  = q_step;
            rem_d   = r_step;
            dbz_d   = 1'b0;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      dvsr_q  <= '0;
      zero_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      dvsr_q  <= dvsr_d;
      zero_q  <= zero_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider_n.sv
// Directed and random checks for seq_divider_n at N=4 and N=8.
// Each scenario task compares outputs against hand-derived or model values.
module tb_seq_divider_n;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       start4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy4, done4, dbz4;
  logic [3:0] q4, r4;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, dbz8;
  logic [7:0] q8, r8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_divider_n #(.N(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start4),
    .dividend(a4), .divisor(b4),
    .busy(busy4), .done(done4),
    .quotient(q4), .remainder(r4),
    .div_by_zero(dbz4)
  );

  seq_divider_n #(.N(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8),
    .dividend(a8), .divisor(b8),
    .busy(busy8), .done(done8),
    .quotient(q8), .remainder(r8),
    .div_by_zero(dbz8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one N=4 division; lat is the cycle index of done after the
  // accepting edge (-1 if never), bc counts busy cycles, nd counts dones.
  task automatic run4(input logic [3:0] a, input logic [3:0] b,
                      output int lat, output int bc, output int nd);
    start4 = 1'b1; a4 = a; b4 = b;
    tick();
    start4 = 1'b0; a4 = ~a; b4 = ~b;
    lat = -1; bc = 0; nd = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy4) bc++;
      if (done4) begin
        nd++;
        if (lat < 0) lat = i;
      end
      if (!busy4) break;
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    checks++;
    if ({busy4, done4, dbz4, q4, r4} !== 11'd0) begin
      errors++;
      $display("FAIL reset4: got busy=%b done=%b dbz=%b q=%h r=%h want all 0",
               busy4, done4, dbz4, q4, r4);
    end
    checks++;
    if ({busy8, done8, dbz8, q8, r8} !== 19'd0) begin
      errors++;
      $display("FAIL reset8: got busy=%b done=%b dbz=%b q=%h r=%h want all 0",
               busy8, done8, dbz8, q8, r8);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [3:0] tv [4][4] = '{
      '{4'd13, 4'd3, 4'd4,  4'd1},
      '{4'd15, 4'd1, 4'd15, 4'd0},
      '{4'd5,  4'd9, 4'd0,  4'd5},
      '{4'd0,  4'd7, 4'd0,  4'd0}
    };
    int lat, bc, nd;
    for (int i = 0; i < 4; i++) begin
      run4(tv[i][0], tv[i][1], lat, bc, nd);
      checks++;
      if (q4 !== tv[i][2] || r4 !== tv[i][3] || dbz4 !== 1'b0) begin
        errors++;
        $display("FAIL basic %0d/%0d: got q=%0d r=%0d dbz=%b want q=%0d r=%0d dbz=0",
                 tv[i][0], tv[i][1], q4, r4, dbz4, tv[i][2], tv[i][3]);
      end
      checks++;
      if (lat != 4 || bc != 5 || nd != 1) begin
        errors++;
        $display("FAIL basic_timing %0d/%0d: got lat=%0d busy=%0d dones=%0d want 4 5 1",
                 tv[i][0], tv[i][1], lat, bc, nd);
      end
    end
  endtask

  task automatic test_div_zero();
    int lat, bc, nd;
    run4(4'd7, 4'd0, lat, bc, nd);
    checks++;
    if (q4 !== 4'hF || r4 !== 4'd7 || dbz4 !== 1'b1) begin
      errors++;
      $display("FAIL dbz 7/0: got q=%h r=%0d dbz=%b want q=f r=7 dbz=1",
               q4, r4, dbz4);
    end
    checks++;
    if (lat != 1 || bc != 2 || nd != 1) begin
      errors++;
      $display("FAIL dbz_timing: got lat=%0d busy=%0d dones=%0d want 1 2 1",
               lat, bc, nd);
    end
    run4(4'd9, 4'd2, lat, bc, nd);
    checks++;
    if (q4 !== 4'd4 || r4 !== 4'd1 || dbz4 !== 1'b0 || lat != 4) begin
      errors++;
      $display("FAIL after_dbz 9/2: got q=%0d r=%0d dbz=%b lat=%0d want 4 1 0 4",
               q4, r4, dbz4, lat);
    end
  endtask

  task automatic test_ignore_busy();
    int nd = 0;
    start4 = 1'b1; a4 = 4'd12; b4 = 4'd5;
    tick();
    a4 = 4'd3; b4 = 4'd1;
    tick();
    start4 = 1'b0;
    tick();
    tick();
    tick();
    checks++;
    if (done4 !== 1'b1) begin
      errors++;
      $display("FAIL ignore_done: got done=%b want 1", done4);
    end
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (done4 || busy4) nd++;
      tick();
    end
    checks++;
    if (q4 !== 4'd2 || r4 !== 4'd2 || nd != 0) begin
      errors++;
      $display("FAIL ignore 12/5: got q=%0d r=%0d extra=%0d want q=2 r=2 extra=0",
               q4, r4, nd);
    end
  endtask

  task automatic test_reset_mid();
    int lat, bc, nd = 0;
    start4 = 1'b1; a4 = 4'd14; b4 = 4'd3;
    tick();
    start4 = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy4, done4, dbz4, q4, r4} !== 11'd0) begin
      errors++;
      $display("FAIL reset_mid: got busy=%b done=%b dbz=%b q=%h r=%h want all 0",
               busy4, done4, dbz4, q4, r4);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (done4 || busy4) nd++;
      tick();
    end
    checks++;
    if (nd != 0) begin
      errors++;
      $display("FAIL reset_mid_nodone: got %0d busy/done cycles want 0", nd);
    end
    run4(4'd9, 4'd4, lat, bc, nd);
    checks++;
    if (q4 !== 4'd2 || r4 !== 4'd1 || lat != 4 || nd != 1) begin
      errors++;
      $display("FAIL after_reset 9/4: got q=%0d r=%0d lat=%0d dones=%0d want 2 1 4 1",
               q4, r4, lat, nd);
    end
  endtask

  task automatic test_random8();
    for (int n = 0; n < 2000; n++) begin
      logic [7:0] a, b, eq, er;
      logic       ez;
      int         lat, want;
      a = 8'($urandom);
      b = (n % 37 == 0) ? 8'd0 : 8'($urandom);
      if (n % 53 == 1) b = 8'd1;
      if (b == 0) begin
        eq = 8'hFF; er = a; ez = 1'b1; want = 1;
      end else begin
        eq = a / b; er = a % b; ez = 1'b0; want = 8;
      end
      start8 = 1'b1; a8 = a; b8 = b;
      tick();
      start8 = 1'b0; a8 = ~a; b8 = ~b;
      lat = -1;
      for (int i = 0; i < 20; i++) begin
        if (done8 && lat < 0) lat = i;
        if (!busy8) break;
        tick();
      end
      checks++;
      if (q8 !== eq || r8 !== er || dbz8 !== ez || lat != want) begin
        errors++;
        $display("FAIL rand8 %0d/%0d: got q=%0d r=%0d dbz=%b lat=%0d want %0d %0d %b %0d",
                 a, b, q8, r8, dbz8, lat, eq, er, ez, want);
      end
      if (!dbz8) begin
        checks++;
        if (16'(q8) * 16'(b) + 16'(r8) != 16'(a) || r8 >= b) begin
          errors++;
          $display("FAIL invariant8 %0d/%0d: got q=%0d r=%0d want q*b+r=a, r<b",
                   a, b, q8, r8);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_ignore_busy();
    test_reset_mid();
    test_random8();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
